// File: rtl/write_share.sv
// write_share: captures a two-word share frame (zero, X, zero, Y) arriving on
// a serial share bus after a start strobe, then presents X and Y together
// with valid_o until the consumer acknowledges.
//
// Optional feature macro: WRITESHARE_GUARD_CHECK_EN
//   defined   -> nonzero share_i in either guard slot sets the sticky err_o
//   undefined -> err_o is tied to 0 and no guard comparator exists

module write_share #(
  parameter int unsigned buswidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [buswidth-1:0] share_i,
  input  logic                ack_i,
  output logic [buswidth-1:0] X_o,
  output logic [buswidth-1:0] Y_o,
  output logic                valid_o,
  output logic                busy_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GUARD1 = 3'd1,
    S_CAPX   = 3'd2,
    S_GUARD2 = 3'd3,
    S_CAPY   = 3'd4,
    S_HOLD   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [buswidth-1:0] x_q, x_d;
  logic [buswidth-1:0] y_q, y_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  // Next-state, share capture and registered status flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;

    unique case (state_q)
      S_IDLE: begin
        // start_i is level-sampled only here, so a start held high across a
        // whole frame cannot re-trigger until the frame has been acknowledged.
        if (start_i) state_d = S_GUARD1;
      end
      S_GUARD1: state_d = S_CAPX;
      S_CAPX: begin
        x_d     = share_i;
        state_d = S_GUARD2;
      end
      S_GUARD2: state_d = S_CAPY;
      S_CAPY: begin
        y_d     = share_i;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Acknowledge drops the shares at the same edge the frame ends, so no
        // stale data survives into the next frame.
        if (ack_i) begin
          x_d     = '0;
          y_d     = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flags are computed from the next state so they are flops aligned with
    // the state they describe.
    valid_d = (state_d == S_HOLD);
    busy_d  = (state_d != S_IDLE);
  end

  // State, share and flag registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      // NOTE: the share words are plain registers, not a memory, so they are
      // reset along with the control state to guarantee zero outputs.
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // X is already loaded while Y is still pending, so the outputs are masked
  // until both shares are present.
  assign X_o     = valid_q ? x_q : '0;
  assign Y_o     = valid_q ? y_q : '0;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;

`ifdef WRITESHARE_GUARD_CHECK_EN
  logic err_q, err_d;

  // Sticky guard-slot violation flag; cleared when a new frame is accepted.
  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && start_i) begin
      err_d = 1'b0;
    end else if ((state_q == S_GUARD1 || state_q == S_GUARD2) &&
                 (share_i != '0)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_write_share.sv
// Testbench for write_share: directed scenarios plus a randomized run checked
// against a frame-level reference model (cycles elapsed since an accepted start).

module tb_write_share;

  localparam int unsigned W = 32;
`ifdef WRITESHARE_GUARD_CHECK_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [W-1:0] share_i = '0;
  logic         ack_i = 1'b0;
  logic [W-1:0] X_o, Y_o;
  logic         valid_o, busy_o, err_o;

  int n_pass  = 0;
  int n_total = 0;

  write_share #(.buswidth(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .share_i (share_i),
    .ack_i   (ack_i),
    .X_o     (X_o),
    .Y_o     (Y_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Observed output bundle: {valid, busy, err, X, Y}.
  logic [2*W+2:0] obs;
  assign obs = {valid_o, busy_o, err_o, X_o, Y_o};

  function automatic logic [2*W+2:0] pack(input logic v, input logic b,
                                          input logic e, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    return {v, b, e, x, y};
  endfunction

  // Apply inputs for the current cycle, then move just past the next edge.
  task automatic tick(input logic s, input logic [W-1:0] sh, input logic a,
                      input logic r);
    start_i = s;
    share_i = sh;
    ack_i   = a;
    rst_i   = r;
    @(posedge clk_i);
    #1;
  endtask

  // Drive one complete frame from IDLE; returns in the first HOLD cycle.
  task automatic run_frame(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] g1, input logic [W-1:0] g2);
    tick(1'b1, '0, 1'b0, 1'b0);
    tick(1'b0, g1, 1'b0, 1'b0);
    tick(1'b0, x,  1'b0, 1'b0);
    tick(1'b0, g2, 1'b0, 1'b0);
    tick(1'b0, y,  1'b0, 1'b0);
  endtask

  task automatic test_reset;
    logic [2*W+2:0] exp;
    exp = pack(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, $urandom, 1'b1, 1'b1);
      n_total++;
      if (obs !== exp) $display("FAIL reset_%0d obs=%h exp=%h", i, obs, exp);
      else n_pass++;
    end
    tick(1'b0, '0, 1'b0, 1'b0);
    n_total++;
    if (obs !== exp) $display("FAIL reset_release obs=%h exp=%h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_basic;
    logic [W-1:0]   sh [5];
    logic [2*W+2:0] exp;
    sh = '{32'h0, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h3C3C3C3C};
    for (int i = 0; i < 5; i++) begin
      tick(i == 0, sh[i], 1'b0, 1'b0);
      if (i < 4) exp = pack(1'b0, 1'b1, 1'b0, '0, '0);
      else       exp = pack(1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h3C3C3C3C);
      n_total++;
      if (obs !== exp) $display("FAIL basic_T%0d obs=%h exp=%h", i + 1, obs, exp);
      else n_pass++;
    end
  endtask

  // Starts in HOLD holding A5A5A5A5 / 3C3C3C3C.
  task automatic test_hold_ack;
    logic [2*W+2:0] exp;
    exp = pack(1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h3C3C3C3C);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, $urandom, 1'b0, 1'b0);
      n_total++;
      if (obs !== exp) $display("FAIL hold_%0d obs=%h exp=%h", i, obs, exp);
      else n_pass++;
    end
    exp = pack(1'b0, 1'b0, 1'b0, '0, '0);
    tick(1'b0, '0, 1'b1, 1'b0);
    n_total++;
    if (obs !== exp) $display("FAIL hold_after_ack obs=%h exp=%h", obs, exp);
    else n_pass++;
    tick(1'b0, '0, 1'b1, 1'b0);
    n_total++;
    if (obs !== exp) $display("FAIL idle_ack_ignored obs=%h exp=%h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    logic [2*W+2:0] exp;
    tick(1'b1, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, 32'h12345678, 1'b0, 1'b0);
    tick(1'b1, '0, 1'b0, 1'b1);
    exp = pack(1'b0, 1'b0, 1'b0, '0, '0);
    n_total++;
    if (obs !== exp) $display("FAIL midreset obs=%h exp=%h", obs, exp);
    else n_pass++;
    run_frame(32'hDEADBEEF, 32'h0BADF00D, '0, '0);
    exp = pack(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0BADF00D);
    n_total++;
    if (obs !== exp) $display("FAIL midreset_fresh obs=%h exp=%h", obs, exp);
    else n_pass++;
    tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_start_held;
    logic [W-1:0]   sh [8];
    logic [2*W+2:0] exp;
    int             frames;
    logic           prev_valid;
    sh = '{32'h0, 32'h0, 32'h11112222, 32'h0, 32'h33334444, 32'h5, 32'h6, 32'h7};
    frames = 0;
    prev_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, sh[i], 1'b0, 1'b0);
      if (valid_o && !prev_valid) frames++;
      prev_valid = valid_o;
    end
    exp = pack(1'b1, 1'b1, 1'b0, 32'h11112222, 32'h33334444);
    n_total++;
    if (obs !== exp) $display("FAIL held_hold obs=%h exp=%h", obs, exp);
    else n_pass++;
    tick(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (valid_o && !prev_valid) frames++;
      prev_valid = valid_o;
      exp = pack(1'b0, 1'b0, 1'b0, '0, '0);
      n_total++;
      if (obs !== exp) $display("FAIL held_idle_%0d obs=%h exp=%h", i, obs, exp);
      else n_pass++;
      tick(1'b0, '0, 1'b0, 1'b0);
    end
    n_total++;
    if (frames !== 1) $display("FAIL held_frames got=%0d exp=1", frames);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0]   sh [5];
    logic [2*W+2:0] exp;
    run_frame(32'hCAFE0001, 32'hCAFE0002, '0, '0);
    tick(1'b0, '0, 1'b1, 1'b0);  // ack at A
    sh = '{32'h0, 32'h0, 32'h0F0F0F0F, 32'h0, 32'hF0F0F0F0};
    for (int i = 0; i < 5; i++) begin
      tick(i == 0, sh[i], 1'b0, 1'b0);
      if (i < 4) exp = pack(1'b0, 1'b1, 1'b0, '0, '0);
      else       exp = pack(1'b1, 1'b1, 1'b0, 32'h0F0F0F0F, 32'hF0F0F0F0);
      n_total++;
      if (obs !== exp) $display("FAIL b2b_A%0d obs=%h exp=%h", i + 2, obs, exp);
      else n_pass++;
    end
    tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_guard;
    logic [2*W+2:0] exp;
    tick(1'b1, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, 32'h77778888, 1'b0, 1'b0);
    tick(1'b0, 32'h00000001, 1'b0, 1'b0);  // GUARD2 violation
    exp = pack(1'b0, 1'b1, GUARD_EN, '0, '0);
    n_total++;
    if (obs !== exp) $display("FAIL guard_err obs=%h exp=%h", obs, exp);
    else n_pass++;
    tick(1'b0, 32'h9999AAAA, 1'b0, 1'b0);
    exp = pack(1'b1, 1'b1, GUARD_EN, 32'h77778888, 32'h9999AAAA);
    n_total++;
    if (obs !== exp) $display("FAIL guard_data obs=%h exp=%h", obs, exp);
    else n_pass++;
    tick(1'b0, '0, 1'b1, 1'b0);
    exp = pack(1'b0, 1'b0, GUARD_EN, '0, '0);
    n_total++;
    if (obs !== exp) $display("FAIL guard_sticky obs=%h exp=%h", obs, exp);
    else n_pass++;
    tick(1'b1, '0, 1'b0, 1'b0);  // accepted start clears err
    exp = pack(1'b0, 1'b1, 1'b0, '0, '0);
    n_total++;
    if (obs !== exp) $display("FAIL guard_clear obs=%h exp=%h", obs, exp);
    else n_pass++;
  endtask

  // Reference model: phase = cycles since the accepted start (0 = idle,
  // 5 = presenting). X arrives two cycles after start, Y four cycles after.
  task automatic test_random;
    int             phase;
    logic [W-1:0]   mx, my;
    bit             merr;
    logic           s, a, r;
    logic [W-1:0]   sh;
    logic [2*W+2:0] exp;
    tick(1'b0, '0, 1'b0, 1'b1);
    phase = 0; mx = '0; my = '0; merr = 1'b0;
    for (int c = 0; c < 400; c++) begin
      exp = pack(phase == 5, phase != 0, merr,
                 (phase == 5) ? mx : '0, (phase == 5) ? my : '0);
      n_total++;
      if (obs !== exp) $display("FAIL rand_%0d obs=%h exp=%h", c, obs, exp);
      else n_pass++;
      s  = ($urandom_range(0, 99) < 30);
      a  = ($urandom_range(0, 99) < 25);
      r  = ($urandom_range(0, 99) < 3);
      sh = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom);
      tick(s, sh, a, r);
      if (r) begin
        phase = 0; mx = '0; my = '0; merr = 1'b0;
      end else if (phase == 0) begin
        if (s) begin
          phase = 1;
          merr  = 1'b0;
        end
      end else if (phase < 5) begin
        if (phase == 2) mx = sh;
        if (phase == 4) my = sh;
        if (GUARD_EN && (phase == 1 || phase == 3) && sh != '0) merr = 1'b1;
        phase++;
      end else if (a) begin
        phase = 0; mx = '0; my = '0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_ack();
    test_mid_reset();
    test_start_held();
    test_back_to_back();
    test_guard();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/write_share.md
WRITE_SHARE -- requirements
Module: write_share

Interface
REQ-001 SHALL have parameter: buswidth, 32, width of each share word and of the serial share bus.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start_i  input  1  frame start strobe; sampled only in IDLE.
REQ-005 SHALL have port: share_i  input  buswidth  serial share bus; frame is zero, X, zero, Y.
REQ-006 SHALL have port: ack_i  input  1  consumer acknowledge; sampled only in HOLD.
REQ-007 SHALL have port: X_o  output  buswidth  captured share X; zero unless valid_o=1.
REQ-008 SHALL have port: Y_o  output  buswidth  captured share Y; zero unless valid_o=1.
REQ-009 SHALL have port: valid_o  output  1  both shares captured and presented.
REQ-010 SHALL have port: busy_o  output  1  high in every state except IDLE.
REQ-011 SHALL have port: err_o  output  1  guard-slot violation flag, sticky (see Configuration).

Function
REQ-012 SHALL implement the FSM IDLE -> GUARD1 -> CAPX -> GUARD2 -> CAPY -> HOLD -> IDLE, one state per cycle except HOLD.
REQ-013 In IDLE, start_i=1 SHALL move to GUARD1; start_i=0 SHALL stay in IDLE.
REQ-014 GUARD1, CAPX, GUARD2 and CAPY SHALL each last exactly one cycle, unconditionally; start_i SHALL be ignored in all of them.
REQ-015 In CAPX, X register SHALL load share_i; in CAPY, Y register SHALL load share_i; the registers SHALL not change in any other state except as stated in REQ-018.
REQ-016 Timing: start_i high in cycle T -> X sampled in T+2 and Y sampled in T+4 -> valid_o=1 from T+5.
REQ-017 In HOLD, valid_o SHALL be 1, X_o=X and Y_o=Y, held until ack_i=1.
REQ-018 ack_i=1 in HOLD SHALL zero the X and Y registers and move to IDLE at the same edge, so valid_o=0 and X_o=Y_o=0 in the next cycle.
REQ-019 X_o and Y_o SHALL be forced to zero whenever valid_o=0. Partial shares SHALL never appear on the outputs.
REQ-020 start_i held high across a frame SHALL start exactly one frame. The next frame SHALL start only if start_i=1 in a later IDLE cycle.
REQ-021 ack_i outside HOLD SHALL have no effect. start_i=1 in HOLD SHALL be ignored.
REQ-022 Back-to-back frames: ack at cycle A with start_i=1 at A+1 SHALL give the next valid_o at A+6.

Reset
REQ-023 rst_i=1 at any clock edge, including mid-frame, SHALL force IDLE and clear the X and Y registers and err_o.
REQ-024 While and after reset, outputs SHALL be valid_o=0, busy_o=0, err_o=0, X_o=0 and Y_o=0 until a new frame completes.

Configuration
REQ-025 Macro WRITESHARE_GUARD_CHECK_EN defined: in GUARD1 or GUARD2, share_i != 0 SHALL set err_o at the next edge.
REQ-026 With the macro defined, err_o SHALL remain set until reset or until start_i is accepted in IDLE, which clears it. A violation SHALL not alter FSM flow or the captured data.
REQ-027 Macro undefined: err_o SHALL be constant 0 and no guard comparator logic SHALL be synthesized.

Verification
REQ-028 Scenario: reset, start_i pulse at T, share_i=0,0xA5A5A5A5,0,0x3C3C3C3C over T+1..T+4 -> valid_o=1 at T+5 with X_o=0xA5A5A5A5 and Y_o=0x3C3C3C3C; X_o/Y_o were 0 through T+4.
REQ-029 Scenario: ack_i withheld for 10 cycles then asserted -> outputs stable for 10 cycles; the cycle after ack, valid_o=0 and X_o=Y_o=0.
REQ-030 Scenario: rst_i asserted at T+3 mid-frame -> next cycle busy_o=0 and valid_o=0; a fresh frame then captures correctly.
REQ-031 Scenario: start_i held high for 8 cycles and ack_i pulsed in HOLD -> exactly one frame completes; busy_o=0 after ack until the next IDLE start.
REQ-032 Scenario: share_i=0x00000001 in GUARD2 -> err_o=1 from the following cycle with the macro defined, and 0 without it; captured X/Y values are unaffected in both builds.
REQ-033 Scenario: ack at A and start_i at A+1 -> second valid_o at A+6 with the new X/Y values and no stale data.
